// File: rtl/ram_sync_nrnw_clr.sv
// ram_sync_nrnw_clr
// N-read / M-write register-file RAM with one-cycle registered reads, an
// optional same-cycle write-to-read bypass and fixed write-port priority
// (highest port index wins). After every reset a clear sequencer walks the
// array writing zero to each entry; the ports stay inert until it finishes.

`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module ram_sync_nrnw_clr #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = `DATA_LEN,
    parameter int DEPTH  = 32,
    parameter int NR     = 4,
    parameter int NW     = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NR-1:0]        re,
    input  logic [NR*ADDR_W-1:0] raddr,
    output logic [NR*DATA_W-1:0] rdata,
    input  logic [NW-1:0]        we,
    input  logic [NW*ADDR_W-1:0] waddr,
    input  logic [NW*DATA_W-1:0] wdata,
    output logic                 ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Addresses are widened by one bit so DEPTH == 2**ADDR_W compares cleanly
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok  [NW];
    logic [DATA_W-1:0] rd_val [NR];

    // A write port is live only in READY and only for an in-range address
    always_comb begin
        for (int j = 0; j < NW; j++) begin
            wr_ok[j] = 1'b0;
            if (state == ST_READY && we[j] &&
                ({1'b0, waddr[j*ADDR_W +: ADDR_W]} < DEPTH_EXT)) begin
                wr_ok[j] = 1'b1;
            end
        end
    end

    // Value each read port would capture this cycle, including the bypass path
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rd_val[i] = '0;
            if ({1'b0, raddr[i*ADDR_W +: ADDR_W]} < DEPTH_EXT) begin
                rd_val[i] = mem[raddr[i*ADDR_W +: ADDR_W]];
                if (BYPASS) begin
                    for (int j = 0; j < NW; j++) begin
                        if (wr_ok[j] &&
                            waddr[j*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W]) begin
                            rd_val[i] = wdata[j*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
    end

    // Clear sequencer and ready flag; reset always restarts the sweep from entry 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_IDX) begin
                state <= ST_READY;
                ready <= 1'b1;
            end
        end
    end

    // Storage: zeroed by the sweep, then written by ports in ascending index order
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int j = 0; j < NW; j++) begin
                    if (wr_ok[j]) begin
                        mem[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Registered read ports; a disabled port keeps its last value
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (state == ST_READY) begin
            for (int i = 0; i < NR; i++) begin
                if (re[i]) begin
                    rdata[i*DATA_W +: DATA_W] <= rd_val[i];
                end
            end
        end
    end

endmodule
